// File: rtl/fetch_unit.sv
// fetch_unit: PC register plus one-outstanding instruction fetch over IMEM_REQ/IMEM_ACK (FETCH_TRAP_EN adds a fetch watchdog).
// Latency: 2 cycles/instruction minimum (S_FETCH with immediate ACK, then S_EXEC); HALT parks the core in S_HALT.
// Backpressure: IMEM_ACK wait holds IMEM_ADDR; STALL holds PC/INST in S_EXEC; only RST leaves S_HALT/S_FAULT.
module fetch_unit #(
  parameter int            AW       = 8,
  parameter int            IW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int            TIMEOUT  = 15
) (
  input  logic          CLK,
  input  logic          RST,
  output logic          IMEM_REQ,
  output logic [AW-1:0] IMEM_ADDR,
  input  logic          IMEM_ACK,
  input  logic [IW-1:0] IMEM_DATA,
  output logic [IW-1:0] INST,
  output logic [3:0]    OP,
  output logic [AW-1:0] PC,
  output logic          INST_VALID,
  input  logic          JUMP,
  input  logic          BRANCH,
  input  logic          STALL,
  input  logic          HALT,
  output logic          HALTED,
  output logic          FAULT
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] pc_q;
  logic [IW-1:0] inst_q;
  logic [AW-1:0] boff;
  logic [AW-1:0] pc_next;

  // 6-bit signed branch offset widened to the PC width so the add wraps mod 2^AW.
  assign boff = {{(AW-6){inst_q[5]}}, inst_q[5:0]};

  always_comb begin
    pc_next = pc_q + AW'(1);
    if (JUMP) begin
      pc_next = inst_q[AW-1:0];
    end else if (BRANCH) begin
      pc_next = pc_q + AW'(1) + boff;
    end
  end

`ifdef FETCH_TRAP_EN
  localparam logic [1:0] S_FAULT = 2'd3;
  localparam int         WDW     = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  logic [WDW-1:0] wdog;
  logic           wd_expire;

  // wdog holds the number of unacked fetch cycles already seen; the TIMEOUT-th one traps.
  always_ff @(posedge CLK) begin
    if (RST || state != S_FETCH || IMEM_ACK) begin
      wdog <= '0;
    end else begin
      wdog <= wdog + WDW'(1);
    end
  end

  assign wd_expire = (wdog == WD_LAST);
  assign FAULT     = (state == S_FAULT);
`else
  assign FAULT     = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_FETCH;
      pc_q   <= RESET_PC;
      inst_q <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (IMEM_ACK) begin
            inst_q <= IMEM_DATA;
            state  <= S_EXEC;
          end
`ifdef FETCH_TRAP_EN
          else if (wd_expire) begin
            state <= S_FAULT;
          end
`endif
        end
        S_EXEC: begin
          if (!STALL) begin
            if (HALT) begin
              state <= S_HALT;
            end else begin
              pc_q  <= pc_next;
              state <= S_FETCH;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign IMEM_REQ   = (state == S_FETCH) && !RST;
  assign IMEM_ADDR  = pc_q;
  assign PC         = pc_q;
  assign INST       = inst_q;
  assign OP         = inst_q[IW-1:IW-4];
  assign INST_VALID = (state == S_EXEC);
  assign HALTED     = (state == S_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed and random instruction streams; a driver plays memory/decoder and a
// negedge monitor scores fetch addresses and executed instructions against a PC model kept here.
module tb_fetch_unit;

  localparam logic [7:0] RPC = 8'h10;

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] inst;
  } exp_t;

  logic        CLK, RST;
  logic        IMEM_REQ, IMEM_ACK;
  logic [7:0]  IMEM_ADDR, PC;
  logic [15:0] IMEM_DATA, INST;
  logic [3:0]  OP;
  logic        INST_VALID, JUMP, BRANCH, STALL, HALT, HALTED, FAULT;

  fetch_unit #(.AW(8), .IW(16), .RESET_PC(RPC), .TIMEOUT(15)) dut (
    .CLK(CLK), .RST(RST), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_ACK(IMEM_ACK), .IMEM_DATA(IMEM_DATA), .INST(INST), .OP(OP), .PC(PC),
    .INST_VALID(INST_VALID), .JUMP(JUMP), .BRANCH(BRANCH), .STALL(STALL),
    .HALT(HALT), .HALTED(HALTED), .FAULT(FAULT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int         chk_cnt = 0;
  int         fail_cnt = 0;
  int         cyc = 0;
  int         last_ack = 0;
  bit         mon_en = 1'b1;
  logic [7:0] mpc;
  logic [7:0] fetch_q[$];
  exp_t       exec_q[$];

  always @(posedge CLK) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Architectural next-PC rule in plain integer arithmetic.
  function automatic logic [7:0] next_pc(input logic [7:0] pc, input logic [15:0] inst,
                                         input bit j, input bit b);
    int off;
    if (j) return inst[7:0];
    if (b) begin
      off = int'(inst[5:0]);
      if (off > 31) off = off - 64;
      return 8'((int'(pc) + 1 + off) & 255);
    end
    return 8'((int'(pc) + 1) & 255);
  endfunction

  always @(negedge CLK) begin
    if (!RST && mon_en) begin
      if (IMEM_REQ) begin
        if (fetch_q.size() == 0) begin
          check("unexpected_req", {31'd0, IMEM_REQ}, 32'd0);
        end else begin
          check("fetch_addr", IMEM_ADDR, fetch_q[0]);
          if (IMEM_ACK) void'(fetch_q.pop_front());
        end
      end
      if (INST_VALID) begin
        if (exec_q.size() == 0) begin
          check("unexpected_valid", {31'd0, INST_VALID}, 32'd0);
        end else begin
          check("exec_pc", PC, exec_q[0].pc);
          check("exec_inst", INST, exec_q[0].inst);
          check("exec_op", OP, exec_q[0].inst[15:12]);
          if (!STALL) void'(exec_q.pop_front());
        end
      end
    end
  end

  task automatic do_reset(input int cycles, input bit ack);
    RST = 1'b1; IMEM_ACK = ack; IMEM_DATA = 16'hBEEF;
    STALL = 1'b0; JUMP = 1'b0; BRANCH = 1'b0; HALT = 1'b0;
    fetch_q.delete();
    exec_q.delete();
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      check("req_in_reset", {31'd0, IMEM_REQ}, 32'd0);
      step();
    end
    RST = 1'b0; IMEM_ACK = 1'b0;
    mpc = RPC;
    fetch_q.push_back(RPC);
  endtask

  // One instruction: wait for REQ, ACK after dly cycles, stall stl cycles, then resolve.
  task automatic run_instr(input logic [15:0] data, input int dly, input int stl,
                           input bit j, input bit b, input bit h);
    int guard = 0;
    while (IMEM_REQ !== 1'b1 && guard < 50) begin
      step();
      guard++;
    end
    if (IMEM_REQ !== 1'b1) begin
      check("fetch_wait_timeout", {31'd0, IMEM_REQ}, 32'd1);
      return;
    end
    for (int i = 0; i < dly; i++) begin
      IMEM_ACK = 1'b0; IMEM_DATA = 16'($urandom);
      step();
    end
    IMEM_ACK = 1'b1; IMEM_DATA = data;
    last_ack = cyc;
    exec_q.push_back('{pc: mpc, inst: data});
    step();
    IMEM_ACK = 1'($urandom); IMEM_DATA = 16'($urandom);
    for (int i = 0; i < stl; i++) begin
      STALL = 1'b1; JUMP = 1'($urandom); BRANCH = 1'($urandom); HALT = 1'($urandom);
      step();
    end
    STALL = 1'b0; JUMP = j; BRANCH = b; HALT = h;
    if (!h) begin
      mpc = next_pc(mpc, data, j, b);
      fetch_q.push_back(mpc);
    end
    step();
    IMEM_ACK = 1'b0; JUMP = 1'b0; BRANCH = 1'b0; HALT = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    int a1;
    int ok;
    int dly, stl;
    do_reset(2, 1'b0);
    @(negedge CLK);
    check("rst_pc", PC, RPC);
    check("rst_inst", INST, 0);
    check("rst_op", OP, 0);
    check("rst_valid", {31'd0, INST_VALID}, 0);
    check("rst_halted", {31'd0, HALTED}, 0);
    check("rst_fault", {31'd0, FAULT}, 0);
    check("rst_req", {31'd0, IMEM_REQ}, 1);
    step();

    run_instr(16'h1234, 0, 0, 0, 0, 0);
    a1 = last_ack;
    run_instr(16'h0020, 0, 0, 1, 0, 0);
    check("throughput_2cyc", last_ack - a1, 2);
    run_instr(16'hF0A5, 0, 0, 1, 1, 0);
    run_instr(16'h2005, 0, 0, 1, 0, 0);
    run_instr(16'h303C, 0, 0, 0, 1, 0);
    run_instr(16'h40FF, 0, 0, 1, 0, 0);
    run_instr(16'h5000, 0, 0, 0, 0, 0);
    run_instr(16'h6030, 3, 4, 1, 0, 0);
    run_instr(16'h7000, 0, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) step();
    @(negedge CLK);
    check("halt_halted", {31'd0, HALTED}, 1);
    check("halt_pc", PC, 8'h30);
    check("halt_req", {31'd0, IMEM_REQ}, 0);
    check("halt_valid", {31'd0, INST_VALID}, 0);
    step();

    do_reset(1, 1'b0);
    @(negedge CLK);
    check("rehalt_pc", PC, RPC);
    check("rehalt_req", {31'd0, IMEM_REQ}, 1);
    check("rehalt_halted", {31'd0, HALTED}, 0);
    step();

    do_reset(1, 1'b1);
    @(negedge CLK);
    check("rst_ack_inst", INST, 0);
    check("rst_ack_valid", {31'd0, INST_VALID}, 0);
    check("rst_ack_pc", PC, RPC);
    step();

`ifdef FETCH_TRAP_EN
    do_reset(1, 1'b0);
    mon_en = 1'b0;
    ok = 1;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      if (IMEM_REQ !== 1'b1) ok = 0;
      step();
    end
    check("trap_req_held", ok, 1);
    @(negedge CLK);
    check("trap_fault", {31'd0, FAULT}, 1);
    check("trap_req_drop", {31'd0, IMEM_REQ}, 0);
    check("trap_pc", PC, RPC);
    step();
    do_reset(1, 1'b0);
    mon_en = 1'b1;
    run_instr(16'h8123, 14, 0, 0, 0, 0);
    @(negedge CLK);
    check("trap_late_ack_fault", {31'd0, FAULT}, 0);
    step();
`else
    ok = 0;
    run_instr(16'h8123, 20, 0, 0, 0, 0);
    @(negedge CLK);
    check("long_wait_fault", {31'd0, FAULT}, ok);
    step();
`endif

    for (int n = 0; n < 200; n++) begin
      dly = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
      stl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_instr(16'($urandom), dly, stl, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 1'b0);
    end
    step();
    check("exec_q_drained", exec_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
    $finish;
  end

endmodule
